// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply controller: multiplier state codes,
// controller state type and the operand magnitude helper.
package muldiv_pkg;

    localparam logic [5:0] MULT_IDLE = 6'd0;
    localparam logic [5:0] MULT_INIT = 6'd1;
    localparam logic [5:0] MULT_WORK = 6'd2;

    // Encoded with the multiplier's own codes so the state drives mult_state directly.
    typedef enum logic [5:0] {
        ST_IDLE = MULT_IDLE,
        ST_INIT = MULT_INIT,
        ST_WORK = MULT_WORK
    } state_e;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling around the unsigned multiplier: operand magnitudes
// going in, and two's-complement negation of the 64-bit product coming out.
module muldiv_sign_fix
    import muldiv_pkg::*;
(
    input  logic        is_signed,
    input  logic        neg,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [63:0] product,
    output logic [31:0] lhs,
    output logic [31:0] rhs,
    output logic [63:0] result
);

    // -2^31 has no positive counterpart; its negation wraps to 32'h8000_0000,
    // which is exactly the unsigned magnitude the multiplier needs.
    assign lhs    = magnitude(rs_val, is_signed);
    assign rhs    = magnitude(rt_val, is_signed);
    assign result = neg ? (~product + 64'd1) : product;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply controller: sequences an external shift-add multiplier through
// IDLE/INIT/WORK, applies the sign fix-up and owns the architectural HI/LO.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WATCHDOG = 48
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [5:0]  mult_state,
    output logic [31:0] mult_lhs,
    output logic [31:0] mult_rhs,
    input  logic [63:0] mult_result,
    input  logic        mult_end
);

    localparam int CW = $clog2(WATCHDOG + 1);

    state_e        state;
    logic [CW-1:0] wd_cnt;
    logic [31:0]   op_rs;
    logic [31:0]   op_rt;
    logic          op_signed;
    logic          op_neg;
    logic [63:0]   fixed_result;

    // Operands are latched at start, so the multiplier inputs stay stable
    // for the whole INIT/WORK window regardless of what rs_val/rt_val do.
    muldiv_sign_fix u_sign_fix (
        .is_signed (op_signed),
        .neg       (op_neg),
        .rs_val    (op_rs),
        .rt_val    (op_rt),
        .product   (mult_result),
        .lhs       (mult_lhs),
        .rhs       (mult_rhs),
        .result    (fixed_result)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would make ordering inside the block matter.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wd_cnt    <= '0;
            op_rs     <= '0;
            op_rt     <= '0;
            op_signed <= 1'b0;
            op_neg    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_rs     <= rs_val;
                        op_rt     <= rt_val;
                        op_signed <= is_signed;
                        op_neg    <= is_signed & (rs_val[31] ^ rt_val[31]);
                        state     <= ST_INIT;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                // mult_end is still high from the multiplier's idle phase here,
                // so it is deliberately not looked at until WORK.
                ST_INIT: begin
                    wd_cnt <= '0;
                    state  <= ST_WORK;
                end
                ST_WORK: begin
                    if (mult_end) begin
                        {hi, lo} <= fixed_result;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end else if (wd_cnt == CW'(WATCHDOG - 1)) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign mult_state = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a cycle-level model of the shift-add multiplier.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, err;
    logic [31:0] hi, lo, mult_lhs, mult_rhs;
    logic [5:0]  mult_state;
    logic [63:0] mult_result;
    logic        mult_end;

    muldiv_ctrl #(.WATCHDOG(48)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .hi          (hi),
        .lo          (lo),
        .mult_state  (mult_state),
        .mult_lhs    (mult_lhs),
        .mult_rhs    (mult_rhs),
        .mult_result (mult_result),
        .mult_end    (mult_end)
    );

    always #5 Clk = ~Clk;

    // Reference multiplier: drops mult_end when it sees INIT, needs 32 WORK cycles,
    // then raises mult_end with the unsigned product. hang freezes it mid-work.
    localparam int MLAT = 32;
    logic       hang = 1'b0;
    logic [7:0] mcnt;

    always @(posedge Clk or posedge reset) begin
        if (reset) begin
            mult_end    <= 1'b1;
            mcnt        <= '0;
            mult_result <= '0;
        end else if (mult_state == MULT_INIT) begin
            mult_end <= 1'b0;
            mcnt     <= '0;
        end else if (mult_state == MULT_WORK) begin
            if (!mult_end && !hang) begin
                if (mcnt == 8'(MLAT - 1)) begin
                    mult_end    <= 1'b1;
                    mult_result <= {32'd0, mult_lhs} * {32'd0, mult_rhs};
                end
                mcnt <= mcnt + 8'd1;
            end
        end else begin
            mult_end <= 1'b1;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    // One multiply from a negedge; returns on the negedge after the done pulse.
    task automatic do_mul(input vec_t v, input string tag, input logic exp_err,
                          input logic with_mtlo, input logic inject);
        int          k;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        prev_hi   = hi;
        prev_lo   = lo;
        start     = 1'b1;
        is_signed = v.sgn;
        rs_val    = v.rs;
        rt_val    = v.rt;
        mtlo      = with_mtlo;
        wdata     = 32'hAA;
        k         = 0;
        @(negedge Clk);
        start = 1'b0;
        mtlo  = 1'b0;
        k     = 1;
        check({tag, " init state"}, 64'(mult_state), 64'(MULT_INIT));
        check({tag, " init busy"}, 64'(busy), 64'd1);
        check({tag, " lhs"}, 64'(mult_lhs), 64'(v.lhs));
        check({tag, " rhs"}, 64'(mult_rhs), 64'(v.rhs));
        if (with_mtlo) check({tag, " mtlo dropped"}, 64'(lo), 64'(prev_lo));
        while (!done && k < 200) begin
            @(negedge Clk);
            k++;
            if (k == 2) check({tag, " work state"}, 64'(mult_state), 64'(MULT_WORK));
            if (inject && k == 5) begin
                mthi   = 1'b1;
                start  = 1'b1;
                wdata  = 32'hAA;
                rs_val = 32'hFF;
                rt_val = 32'hFF;
            end
            if (inject && k == 6) begin
                mthi  = 1'b0;
                start = 1'b0;
                check({tag, " mthi ignored"}, 64'(hi), 64'(prev_hi));
                check({tag, " lhs held"}, 64'(mult_lhs), 64'(v.lhs));
            end
        end
        check({tag, " done seen"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(k), 64'd35);
        check({tag, " hi"}, 64'(hi), 64'(v.hi));
        check({tag, " lo"}, 64'(lo), 64'(v.lo));
        check({tag, " err"}, 64'(err), 64'(exp_err));
        @(negedge Clk);
        check({tag, " done pulse"}, 64'(done), 64'd0);
        check({tag, " busy after"}, 64'(busy), 64'd0);
        check({tag, " idle after"}, 64'(mult_state), 64'(MULT_IDLE));
    endtask

    initial begin
        int   work_n;
        logic done_seen;
        logic [31:0] keep_hi, keep_lo;

        vecs[0] = '{1'b0, 32'd7,         32'd6,         32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A};
        vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'd5,         32'd3,         32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         32'h0000_0000, 32'h8000_0000};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd1,         32'h0000_0000, 32'h0000_0001};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'h0000_0002};
        vecs[7] = '{1'b1, 32'd0,         32'hFFFF_FFFB, 32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000};

        #1 reset = 1'b1;
        #1;
        check("reset state", 64'(mult_state), 64'(MULT_IDLE));
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        check("reset lhs rhs", {mult_lhs, mult_rhs}, 64'd0);
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 8; i++) do_mul(vecs[i], $sformatf("vec%0d", i), 1'b0, 1'b0, 1'b0);

        // Requests arriving while busy are dropped.
        do_mul(vecs[0], "busy inject", 1'b0, 1'b0, 1'b1);

        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h55;
        @(negedge Clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi+mtlo hi", 64'(hi), 64'h55);
        check("mthi+mtlo lo", 64'(lo), 64'h55);

        do_mul(vecs[0], "start+mtlo", 1'b0, 1'b1, 1'b0);

        // Watchdog: multiplier never finishes.
        hang      = 1'b1;
        keep_hi   = hi;
        keep_lo   = lo;
        work_n    = 0;
        done_seen = 1'b0;
        start     = 1'b1;
        is_signed = 1'b0;
        rs_val    = 32'd9;
        rt_val    = 32'd9;
        @(negedge Clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (done) done_seen = 1'b1;
            if (mult_state == MULT_WORK) begin
                work_n++;
                if (work_n == 48) check("wd err before limit", 64'(err), 64'd0);
            end else if (work_n > 0) begin
                break;
            end
        end
        hang = 1'b0;
        check("wd work cycles", 64'(work_n), 64'd48);
        check("wd err", 64'(err), 64'd1);
        check("wd idle", 64'(mult_state), 64'(MULT_IDLE));
        check("wd busy", 64'(busy), 64'd0);
        check("wd hi kept", 64'(hi), 64'(keep_hi));
        check("wd lo kept", 64'(lo), 64'(keep_lo));
        check("wd no done", 64'(done_seen), 64'd0);
        @(negedge Clk);

        // err survives a normal multiply.
        do_mul(vecs[1], "err sticky", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset 10 cycles into WORK.
        start     = 1'b1;
        is_signed = vecs[3].sgn;
        rs_val    = vecs[3].rs;
        rt_val    = vecs[3].rt;
        @(negedge Clk);
        start = 1'b0;
        repeat (11) @(negedge Clk);
        check("pre-reset work", 64'(mult_state), 64'(MULT_WORK));
        #2 reset = 1'b1;
        #1;
        check("mid reset state", 64'(mult_state), 64'(MULT_IDLE));
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset err", 64'(err), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        check("mid reset hilo", {hi, lo}, 64'd0);
        check("mid reset lhs rhs", {mult_lhs, mult_rhs}, 64'd0);
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        do_mul(vecs[2], "after reset", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter: WATCHDOG, default 48, maximum cycles spent in WORK before abort.
REQ-002 Port: Clk  in  1  single clock; all state updates on posedge Clk.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  request one multiply, sampled in IDLE only.
REQ-005 Port: is_signed  in  1  operand format: 1 = MIPS mult (two's complement), 0 = multu; sampled with start.
REQ-006 Port: rs_val, rt_val  in  32 each  operands, sampled with start.
REQ-007 Port: mthi, mtlo  in  1 each  direct write requests to HI / LO.
REQ-008 Port: wdata  in  32  data for mthi/mtlo.
REQ-009 Port: busy  out  1  high while a multiply is in flight (INIT or WORK).
REQ-010 Port: done  out  1  one-cycle pulse after HI/LO update from a multiply.
REQ-011 Port: err  out  1  sticky watchdog-abort flag.
REQ-012 Port: hi, lo  out  32 each  architectural HI/LO registers.
REQ-013 Port: mult_state  out  6  state code driven to the shift-add multiplier.
REQ-014 Port: mult_lhs, mult_rhs  out  32 each  unsigned operand magnitudes to the multiplier.
REQ-015 Port: mult_result  in  64  multiplier unsigned product.
REQ-016 Port: mult_end  in  1  multiplier completion flag; high while the multiplier is idle.

Function
REQ-017 FSM states: IDLE, INIT, WORK; mult_state SHALL equal the state code each cycle.
REQ-018 IDLE + start: latch operands, sign flag and neg = is_signed & (rs_val[31] ^ rt_val[31]), then go to INIT; busy high from the next cycle.
REQ-019 INIT lasts exactly one cycle, then WORK; mult_end SHALL NOT be sampled in INIT, because it is still high from idle.
REQ-020 mult_lhs/mult_rhs: signed operation uses the magnitude, negating when bit 31 is set; -2^31 maps to 32'h8000_0000; unsigned operation passes operands through; held stable from INIT through WORK.
REQ-021 WORK + mult_end=1 at an edge: {hi,lo} <= neg ? -mult_result (64-bit two's complement) : mult_result; go to IDLE; done=1 for exactly the next cycle.
REQ-022 With the reference multiplier timing, latency from the start edge to the HI/LO update edge is 35 cycles; the controller SHALL depend only on mult_end, never on a fixed count.
REQ-023 WORK cycle counter reaching WATCHDOG without mult_end: err <= 1, go to IDLE, HI/LO unchanged, no done pulse.
REQ-024 mthi/mtlo in IDLE: write wdata to hi/lo on that edge; both asserted together writes both.
REQ-025 mthi/mtlo while busy: ignored; the upstream stall is the caller's responsibility.
REQ-026 start while busy: ignored, with no queuing.
REQ-027 start together with mthi/mtlo in IDLE: start wins; the mthi/mtlo write is dropped.
REQ-028 done and err SHALL never be high due to the same operation.

Reset
REQ-029 Asynchronous reset: state IDLE, mult_state 6'd0, hi/lo 0, busy 0, done 0, err 0, latched operands 0.
REQ-030 Reset mid-operation aborts immediately with the same values; no partial HI/LO write.
REQ-031 err SHALL be cleared only by reset.

Structure
REQ-032 Package muldiv_pkg SHALL hold the mult_state codes MULT_IDLE=6'd0, MULT_INIT=6'd1, MULT_WORK=6'd2, plus the FSM state enum.
REQ-033 The multiplier instance lives outside this block; the controller only drives and observes its ports.
REQ-034 One combinational sub-module, muldiv_sign_fix, SHALL perform operand magnitude and result negation.

Verification
REQ-035 Directed scenario, unsigned: multu 7 x 6 with a multiplier model returning 42 -> mult_state IDLE,INIT,WORK...; hi=0, lo=42; done one cycle; busy low after.
REQ-036 Directed scenario, signed: mult -3 x 5 -> mult_lhs=3, mult_rhs=5; model returns 15 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
REQ-037 Directed scenario, signed corner: mult 32'h8000_0000 x 32'hFFFF_FFFF -> mult_lhs=32'h8000_0000, mult_rhs=1; hi=0, lo=32'h8000_0000.
REQ-038 Directed scenario, busy and simultaneous requests: mthi(0xAA) and a second start during WORK ignored; mthi+mtlo with wdata=0x55 in IDLE -> hi=lo=0x55; start+mtlo together -> only the multiply result lands.
REQ-039 Directed scenario, watchdog: hold mult_end=0 in WORK for 48 cycles -> err=1, IDLE, HI/LO unchanged, no done.
REQ-040 Directed scenario, reset: assert reset 10 cycles into WORK -> all outputs at reset values asynchronously; the next multiply completes normally.
